param_register_file: RTL and testbench
======================================

PARAM_REGISTER_FILE -- requirements
Module: param_register_file

Interface
REQ-001 The block SHALL have parameter DATA_W, default 18, meaning register width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning address width; DEPTH = 2**ADDR_W registers.
REQ-003 The block SHALL have parameter ZERO_REG, default 0, meaning when 1 register 0 reads as zero and ignores writes.
REQ-004 The block SHALL have one clock; reset is synchronous and active-high, and the ports SHALL be named clk and rst.
REQ-005 Ports: clk  in  1  clock, all state on rising edge.
REQ-006 Ports: rst  in  1  synchronous active-high reset.
REQ-007 Ports: write_enable  in  1; write_addr  in  ADDR_W; write_data  in  DATA_W; these form the write port.
REQ-008 Ports: read_addr1, read_addr2  in  ADDR_W; read port addresses.
REQ-009 Ports: data_out1, data_out2  out  DATA_W; registered read data.
REQ-010 Ports: reserve_en  in  1; reserve_addr  in  ADDR_W; these mark a register as pending a future write.
REQ-011 Ports: busy1, busy2  out  1; registered scoreboard bit of read_addr1/read_addr2.
REQ-012 Ports: clear_req  in  1, requests zeroing of all registers; ready  out  1, high when the block accepts writes/reserves.

Function
REQ-013 Reads SHALL have 1-cycle latency: data_outN and busyN at edge k+1 reflect read_addrN sampled at edge k.
REQ-014 A write to address A, when accepted at edge k, SHALL update the register at edge k.
REQ-015 When a read address equals an accepted write_addr in the same cycle, data_out SHALL return write_data (write-through bypass), not the old value.
REQ-016 With ZERO_REG=1, writes to address 0 SHALL be dropped, reads of address 0 SHALL return 0, and busy for address 0 SHALL always be 0.
REQ-017 An accepted write SHALL clear the scoreboard bit of write_addr; an accepted reserve SHALL set the scoreboard bit of reserve_addr.
REQ-018 When a write and a reserve target the same address in the same cycle, the scoreboard bit SHALL end set (reserve wins).
REQ-019 Bypass SHALL also apply to busy: busyN reflects the scoreboard value after same-cycle write/reserve updates.
REQ-020 The FSM SHALL have states IDLE and CLEAR; ready = (state == IDLE).
REQ-021 In IDLE, clear_req=1 SHALL move the FSM to CLEAR with sweep counter 0 and all scoreboard bits cleared at that edge.
REQ-022 In CLEAR, the FSM SHALL write 0 to register[counter] each cycle and increment the counter.
REQ-023 The FSM SHALL return to IDLE after the edge that zeroes register DEPTH-1, so CLEAR lasts exactly DEPTH cycles.
REQ-024 In CLEAR, write_enable, reserve_en and clear_req SHALL be ignored; reads SHALL remain functional and return current contents (swept registers read 0).
REQ-025 Counter wrap SHALL NOT occur: the counter is ADDR_W bits and the exit condition is tested at DEPTH-1.
REQ-026 Writes and reserves SHALL be accepted only when ready=1.

Reset
REQ-027 rst=1 at an edge SHALL force state=CLEAR, counter=0, all scoreboard bits=0, data_out1=data_out2=0, busy1=busy2=0 and ready=0 from the next cycle.
REQ-028 After rst deasserts, the sweep SHALL run DEPTH cycles; ready SHALL rise on the cycle after register DEPTH-1 is zeroed.
REQ-029 rst asserted mid-sweep SHALL restart the sweep from counter 0.

Structure
REQ-030 The FSM state enum and default DATA_W/ADDR_W constants SHALL live in a shared package, regfile_pkg.
REQ-031 The scoreboard (DEPTH bits, set/clear/read with bypass) SHALL be one sub-module, regfile_scoreboard; storage, bypass and the FSM SHALL stay in the top module.

Verification
REQ-032 Reset: pulse rst 1 cycle, then idle -> ready=0 for 16 cycles, ready=1 after; read all 16 addresses -> 0.
REQ-033 Write/read: write 18'd42 to addr 3, then read addr 3 -> data_out1=42 after 1 cycle; write 18'hA5 to addr 1 while reading addr 1 the same cycle -> data_out=18'hA5 (bypass).
REQ-034 Scoreboard: reserve addr 5 -> busy=1 on read of 5; write addr 5 = 7 -> busy=0; reserve and write addr 6 in the same cycle -> busy=1.
REQ-035 Clear: fill addrs 0..15 with i+1, pulse clear_req -> ready=0 for 16 cycles; a write of 99 to addr 2 during CLEAR is dropped; all reads return 0 after.
REQ-036 ZERO_REG=1: write 18'h3FFFF to addr 0 -> read returns 0; reserve addr 0 -> busy stays 0.
REQ-037 Mid-sweep reset: assert rst at sweep cycle 8 -> ready stays low 16 more cycles after rst deasserts.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared FSM state type and default sizing for the parameterised register file.
package regfile_pkg;

    localparam int DEFAULT_DATA_W = 18;
    localparam int DEFAULT_ADDR_W = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by reserve, cleared by write,
// with registered read-out that already reflects this cycle's updates.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear_all_i,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    input  logic [ADDR_W-1:0] rd_addr2_i,
    output logic              busy1_o,
    output logic              busy2_o
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DEPTH-1:0] pend_q;
    logic [DEPTH-1:0] pend_d;
    logic             busy1_q;
    logic             busy2_q;

    // Set is applied after clear so a same-address reserve wins over a write.
    always_comb begin
        pend_d = pend_q;
        if (clr_en_i) begin
            pend_d[clr_addr_i] = 1'b0;
        end
        if (set_en_i) begin
            pend_d[set_addr_i] = 1'b1;
        end
        if (clear_all_i) begin
            pend_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= '0;
            busy1_q <= 1'b0;
            busy2_q <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            busy1_q <= pend_d[rd_addr1_i];
            busy2_q <= pend_d[rd_addr2_i];
        end
    end

    assign busy1_o = busy1_q;
    assign busy2_o = busy2_q;

endmodule

// File: rtl/param_register_file.sv
// Two-read, one-write register file with write-through bypass, a pending-write
// scoreboard and a sweep FSM that zeroes every register after reset or on request.
module param_register_file
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [ADDR_W-1:0] read_addr1,
    input  logic [ADDR_W-1:0] read_addr2,
    output logic [DATA_W-1:0] data_out1,
    output logic [DATA_W-1:0] data_out2,
    input  logic              reserve_en,
    input  logic [ADDR_W-1:0] reserve_addr,
    output logic              busy1,
    output logic              busy2,
    input  logic              clear_req,
    output logic              ready
);

    localparam int                DEPTH     = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;
    logic              clear_all;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] rdata1_q;
    logic [DATA_W-1:0] rdata1_d;
    logic [DATA_W-1:0] rdata2_q;
    logic [DATA_W-1:0] rdata2_d;

    logic              user_wr;
    logic              user_rsv;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    assign ready    = (state_q == ST_IDLE);
    assign user_wr  = ready && write_enable && !((ZERO_REG != 0) && (write_addr == '0));
    assign user_rsv = ready && reserve_en && !((ZERO_REG != 0) && (reserve_addr == '0));

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clear_all = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    state_d   = ST_CLEAR;
                    cnt_d     = '0;
                    clear_all = 1'b1;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The sweep owns the single write port while CLEAR is active.
    always_comb begin
        mem_we    = user_wr;
        mem_waddr = write_addr;
        mem_wdata = write_data;
        if (state_q == ST_CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = cnt_q;
            mem_wdata = '0;
        end
    end

    always_comb begin
        rdata1_d = (mem_we && (mem_waddr == read_addr1)) ? mem_wdata : regs_q[read_addr1];
        rdata2_d = (mem_we && (mem_waddr == read_addr2)) ? mem_wdata : regs_q[read_addr2];
        if ((ZERO_REG != 0) && (read_addr1 == '0)) begin
            rdata1_d = '0;
        end
        if ((ZERO_REG != 0) && (read_addr2 == '0)) begin
            rdata2_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            cnt_q    <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdata1_q <= rdata1_d;
            rdata2_q <= rdata2_d;
        end
    end

    // Storage has no reset of its own; the sweep that follows reset zeroes it.
    always_ff @(posedge clk) begin
        if (!rst && mem_we) begin
            regs_q[mem_waddr] <= mem_wdata;
        end
    end

    assign data_out1 = rdata1_q;
    assign data_out2 = rdata2_q;

    regfile_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .clear_all_i (clear_all),
        .set_en_i    (user_rsv),
        .set_addr_i  (reserve_addr),
        .clr_en_i    (user_wr),
        .clr_addr_i  (write_addr),
        .rd_addr1_i  (read_addr1),
        .rd_addr2_i  (read_addr2),
        .busy1_o     (busy1),
        .busy2_o     (busy2)
    );

endmodule

// File: tb/tb_param_register_file.sv
// Scenario bench for param_register_file: a behavioural model queues the expected
// outputs for every driven cycle and each scenario task compares them one edge later.
module tb_param_register_file;

    localparam int DW    = 18;
    localparam int AW    = 4;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic          re;
        logic [AW-1:0] rsa;
    } stim_t;

    typedef struct {
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          b1;
        logic          b2;
        logic          rdy;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          writeEnable;
    logic [AW-1:0] writeAddr;
    logic [DW-1:0] writeData;
    logic [AW-1:0] readAddr1;
    logic [AW-1:0] readAddr2;
    logic          reserveEn;
    logic [AW-1:0] reserveAddr;
    logic          clearReq;

    logic [DW-1:0] dataOut1, dataOut2, zDataOut1, zDataOut2;
    logic          busy1, busy2, ready, zBusy1, zBusy2, zReady;

    exp_t          expq[$];
    int            checkCount = 0;
    int            passCount  = 0;

    logic [DW-1:0] mMem [DEPTH];
    logic          mSb  [DEPTH];
    logic          mClear;
    int            mCnt;

    always #5 clk = ~clk;

    param_register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(0)) dut (
        .clk(clk), .rst(rst),
        .write_enable(writeEnable), .write_addr(writeAddr), .write_data(writeData),
        .read_addr1(readAddr1), .read_addr2(readAddr2),
        .data_out1(dataOut1), .data_out2(dataOut2),
        .reserve_en(reserveEn), .reserve_addr(reserveAddr),
        .busy1(busy1), .busy2(busy2),
        .clear_req(clearReq), .ready(ready)
    );

    param_register_file #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1)) dutZero (
        .clk(clk), .rst(rst),
        .write_enable(writeEnable), .write_addr(writeAddr), .write_data(writeData),
        .read_addr1(readAddr1), .read_addr2(readAddr2),
        .data_out1(zDataOut1), .data_out2(zDataOut2),
        .reserve_en(reserveEn), .reserve_addr(reserveAddr),
        .busy1(zBusy1), .busy2(zBusy2),
        .clear_req(clearReq), .ready(zReady)
    );

    // Drive one cycle of stimulus, advance the model, queue what the DUT must show after the edge.
    task automatic applyStimulus(input logic r, input logic cr, input stim_t s);
        exp_t e;
        rst         = r;
        clearReq    = cr;
        writeEnable = s.we;
        writeAddr   = s.wa;
        writeData   = s.wd;
        readAddr1   = s.ra1;
        readAddr2   = s.ra2;
        reserveEn   = s.re;
        reserveAddr = s.rsa;
        if (r) begin
            e.d1 = '0; e.d2 = '0; e.b1 = 1'b0; e.b2 = 1'b0;
            mClear = 1'b1;
            mCnt   = 0;
            foreach (mSb[i]) mSb[i] = 1'b0;
        end else if (!mClear) begin
            e.d1 = (s.we && s.wa == s.ra1) ? s.wd : mMem[s.ra1];
            e.d2 = (s.we && s.wa == s.ra2) ? s.wd : mMem[s.ra2];
            if (s.we) mSb[s.wa] = 1'b0;
            if (s.re) mSb[s.rsa] = 1'b1;
            if (cr) begin
                foreach (mSb[i]) mSb[i] = 1'b0;
                mClear = 1'b1;
                mCnt   = 0;
            end
            e.b1 = mSb[s.ra1];
            e.b2 = mSb[s.ra2];
            if (s.we) mMem[s.wa] = s.wd;
        end else begin
            e.d1 = mMem[s.ra1];
            e.d2 = mMem[s.ra2];
            e.b1 = mSb[s.ra1];
            e.b2 = mSb[s.ra2];
            mMem[mCnt] = '0;
            if (mCnt == DEPTH - 1) begin
                mClear = 1'b0;
                mCnt   = 0;
            end else begin
                mCnt++;
            end
        end
        e.rdy = !mClear;
        expq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t  e;
        stim_t s;
        int    lowCycles;
        s = '0;
        applyStimulus(1'b1, 1'b0, s);
        e = expq.pop_front();
        checkCount++;
        if ({dataOut1, dataOut2, busy1, busy2, ready} !== {e.d1, e.d2, e.b1, e.b2, e.rdy})
            $display("[TB] FAIL reset_outputs: got %h expected %h",
                     {dataOut1, dataOut2, busy1, busy2, ready}, {e.d1, e.d2, e.b1, e.b2, e.rdy});
        else passCount++;
        checkCount++;
        if ({zDataOut1, zDataOut2, zBusy1, zBusy2, zReady} !== 39'd0)
            $display("[TB] FAIL reset_outputs_zero_reg: got %h expected 0",
                     {zDataOut1, zDataOut2, zBusy1, zBusy2, zReady});
        else passCount++;

        lowCycles = 1;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
            if (ready !== 1'b1) lowCycles++;
        end
        checkCount++;
        if (lowCycles !== DEPTH)
            $display("[TB] FAIL reset_ready_delay: got %0d low cycles expected %0d", lowCycles, DEPTH);
        else passCount++;
        checkCount++;
        if (zReady !== 1'b1)
            $display("[TB] FAIL reset_ready_zero_reg: got %b expected 1", zReady);
        else passCount++;

        for (int i = 0; i < DEPTH; i++) begin
            s.ra1 = AW'(i);
            s.ra2 = AW'(DEPTH - 1 - i);
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, dataOut2, busy1, busy2} !== {e.d1, e.d2, e.b1, e.b2})
                $display("[TB] FAIL read_after_reset[%0d]: got %h expected %h", i,
                         {dataOut1, dataOut2, busy1, busy2}, {e.d1, e.d2, e.b1, e.b2});
            else passCount++;
        end
    endtask

    task automatic test_write_read();
        stim_t tbl [5];
        exp_t  e;
        tbl = '{
            '{1'b1, 4'd3, 18'd42,     4'd0, 4'd0, 1'b0, 4'd0},
            '{1'b0, 4'd0, 18'd0,      4'd3, 4'd3, 1'b0, 4'd0},
            '{1'b1, 4'd1, 18'hA5,     4'd1, 4'd1, 1'b0, 4'd0},
            '{1'b0, 4'd0, 18'd0,      4'd1, 4'd3, 1'b0, 4'd0},
            '{1'b1, 4'd3, 18'h12345,  4'd3, 4'd1, 1'b0, 4'd0}
        };
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, tbl[i]);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, dataOut2, busy1, busy2, ready} !== {e.d1, e.d2, e.b1, e.b2, e.rdy})
                $display("[TB] FAIL write_read[%0d]: got %h expected %h", i,
                         {dataOut1, dataOut2, busy1, busy2, ready}, {e.d1, e.d2, e.b1, e.b2, e.rdy});
            else passCount++;
        end
    endtask

    task automatic test_scoreboard();
        stim_t tbl [6];
        exp_t  e;
        tbl = '{
            '{1'b0, 4'd0, 18'd0, 4'd5, 4'd6, 1'b1, 4'd5},
            '{1'b0, 4'd0, 18'd0, 4'd5, 4'd6, 1'b0, 4'd0},
            '{1'b1, 4'd5, 18'd7, 4'd5, 4'd6, 1'b0, 4'd0},
            '{1'b1, 4'd6, 18'd9, 4'd6, 4'd5, 1'b1, 4'd6},
            '{1'b0, 4'd0, 18'd0, 4'd6, 4'd5, 1'b0, 4'd0},
            '{1'b0, 4'd0, 18'd0, 4'd5, 4'd6, 1'b0, 4'd0}
        };
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, tbl[i]);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, dataOut2, busy1, busy2, ready} !== {e.d1, e.d2, e.b1, e.b2, e.rdy})
                $display("[TB] FAIL scoreboard[%0d]: got %h expected %h", i,
                         {dataOut1, dataOut2, busy1, busy2, ready}, {e.d1, e.d2, e.b1, e.b2, e.rdy});
            else passCount++;
        end
    endtask

    task automatic test_clear();
        stim_t s;
        exp_t  e;
        int    lowCycles;
        for (int i = 0; i < DEPTH; i++) begin
            s     = '0;
            s.we  = 1'b1;
            s.wa  = AW'(i);
            s.wd  = DW'(i + 1);
            s.ra1 = AW'(i);
            s.ra2 = AW'((i + 1) % DEPTH);
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, dataOut2, ready} !== {e.d1, e.d2, e.rdy})
                $display("[TB] FAIL clear_fill[%0d]: got %h expected %h", i,
                         {dataOut1, dataOut2, ready}, {e.d1, e.d2, e.rdy});
            else passCount++;
        end

        s = '0;
        applyStimulus(1'b0, 1'b1, s);
        e = expq.pop_front();
        checkCount++;
        if ({busy1, busy2, ready} !== {e.b1, e.b2, e.rdy})
            $display("[TB] FAIL clear_enter: got %b expected %b",
                     {busy1, busy2, ready}, {e.b1, e.b2, e.rdy});
        else passCount++;

        lowCycles = 1;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
            s = '0;
            if (i == 2) begin
                s.we  = 1'b1;
                s.wa  = 4'd2;
                s.wd  = 18'd99;
                s.re  = 1'b1;
                s.rsa = 4'd2;
            end
            applyStimulus(1'b0, (i == 3), s);
            e = expq.pop_front();
            if (ready !== 1'b1) lowCycles++;
        end
        checkCount++;
        if (lowCycles !== DEPTH)
            $display("[TB] FAIL clear_ready_delay: got %0d low cycles expected %0d", lowCycles, DEPTH);
        else passCount++;

        for (int i = 0; i < DEPTH; i++) begin
            s     = '0;
            s.ra1 = AW'(i);
            s.ra2 = 4'd2;
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, dataOut2, busy1, busy2} !== {e.d1, e.d2, e.b1, e.b2})
                $display("[TB] FAIL clear_readback[%0d]: got %h expected %h", i,
                         {dataOut1, dataOut2, busy1, busy2}, {e.d1, e.d2, e.b1, e.b2});
            else passCount++;
        end
    endtask

    task automatic test_zero_reg();
        stim_t         tbl  [5];
        logic [DW-1:0] zExp [5];
        exp_t          e;
        tbl = '{
            '{1'b1, 4'd0, 18'h3FFFF, 4'd0, 4'd0, 1'b0, 4'd0},
            '{1'b0, 4'd0, 18'd0,     4'd0, 4'd0, 1'b0, 4'd0},
            '{1'b0, 4'd0, 18'd0,     4'd0, 4'd0, 1'b1, 4'd0},
            '{1'b0, 4'd0, 18'd0,     4'd0, 4'd0, 1'b0, 4'd0},
            '{1'b1, 4'd4, 18'h1234,  4'd4, 4'd0, 1'b0, 4'd0}
        };
        zExp = '{18'd0, 18'd0, 18'd0, 18'd0, 18'h1234};
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, tbl[i]);
            e = expq.pop_front();
            checkCount++;
            if ({dataOut1, busy1} !== {e.d1, e.b1})
                $display("[TB] FAIL zero_reg_plain[%0d]: got %h expected %h", i,
                         {dataOut1, busy1}, {e.d1, e.b1});
            else passCount++;
            checkCount++;
            if ({zDataOut1, zDataOut2, zBusy1, zBusy2} !== {zExp[i], 18'd0, 1'b0, 1'b0})
                $display("[TB] FAIL zero_reg[%0d]: got %h expected %h", i,
                         {zDataOut1, zDataOut2, zBusy1, zBusy2}, {zExp[i], 18'd0, 1'b0, 1'b0});
            else passCount++;
        end
    endtask

    task automatic test_mid_sweep_reset();
        stim_t s;
        exp_t  e;
        int    lowCycles;
        s = '0;
        applyStimulus(1'b0, 1'b1, s);
        e = expq.pop_front();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
        end
        checkCount++;
        if (ready !== 1'b0)
            $display("[TB] FAIL mid_sweep_low: got %b expected 0", ready);
        else passCount++;

        applyStimulus(1'b1, 1'b0, s);
        e = expq.pop_front();
        checkCount++;
        if ({dataOut1, dataOut2, busy1, busy2, ready} !== {e.d1, e.d2, e.b1, e.b2, e.rdy})
            $display("[TB] FAIL mid_sweep_reset_outputs: got %h expected %h",
                     {dataOut1, dataOut2, busy1, busy2, ready}, {e.d1, e.d2, e.b1, e.b2, e.rdy});
        else passCount++;

        lowCycles = 1;
        for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
            applyStimulus(1'b0, 1'b0, s);
            e = expq.pop_front();
            if (ready !== 1'b1) lowCycles++;
        end
        checkCount++;
        if (lowCycles !== DEPTH)
            $display("[TB] FAIL mid_sweep_ready_delay: got %0d low cycles expected %0d", lowCycles, DEPTH);
        else passCount++;
    endtask

    initial begin
        foreach (mMem[i]) mMem[i] = '0;
        foreach (mSb[i])  mSb[i]  = 1'b0;
        mClear = 1'b1;
        mCnt   = 0;
        test_reset();
        test_write_read();
        test_scoreboard();
        test_clear();
        test_zero_reg();
        test_mid_sweep_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached after %0d checks", checkCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
